psum_drain_fp16: RTL and testbench

- Output-side collector at the bottom edge of the weight-stationary FP16 systolic array.
- Each column's psum_out word arrives one cycle later than the word of the column to its left, because of the ifmap skew.
- The block samples each column at the computed cycle, removes the skew, and packs one aligned row-vector of psums per input vector.
- Words are buffered in a FIFO and presented downstream on a valid/ready stream, with last, done and overflow reporting.

---
 rtl/fp16_pkg.sv | 17 +
 rtl/psum_fifo.sv | 52 +++++
 rtl/psum_drain_fp16.sv | 153 +++++++++++++++
 tb/tb_psum_drain_fp16.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared constants and types for the FP16 systolic array edge logic.
// Used by the psum drain and the ifmap feeder.
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam int MAC_LAT = 9;
    localparam int ROWS_DEF = 4;
    localparam int ARRAY_LAT_DEF = ROWS_DEF * MAC_LAT;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DRAIN
    } drain_state_t;

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// A push while full is accepted only if a pop happens in the same cycle.
module psum_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/psum_drain_fp16.sv
// Bottom-edge psum collector: deskews the columns, packs one word per
// input vector and streams it out through a small FIFO.
module psum_drain_fp16
    import fp16_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int ARRAY_LAT  = ARRAY_LAT_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vec,
    input  logic [FP16_W*COLS-1:0] psum_col,
    output logic [FP16_W*COLS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int W  = FP16_W * COLS;
    localparam int CW = CNT_W + 2;
    localparam logic [CW-1:0] SKEW = CW'(COLS - 1);

    drain_state_t     state;
    drain_state_t     state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    cap_end;
    logic [CNT_W-1:0] nv_q;
    logic [CNT_W-1:0] pop_cnt;
    logic             zero_done;
    logic             ovf;
    logic             start_ok;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [W-1:0]     push_word;
    logic [W-1:0]     head;
    logic [FP16_W-1:0] aligned [COLS];

    // Lane c waits COLS-1-c cycles so every lane lines up with the last one.
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign aligned[c] = psum_col[c*FP16_W +: FP16_W];
        end else begin : g_dly
            logic [FP16_W-1:0] sr [D];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < D; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= psum_col[c*FP16_W +: FP16_W];
                    for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
                end
            end
            assign aligned[c] = sr[D-1];
        end
    end

    always_comb begin
        push_word = '0;
        for (int c = 0; c < COLS; c++)
            push_word[c*FP16_W +: FP16_W] = aligned[c];
    end

    assign start_ok  = start && (state == IDLE);
    assign cap_end   = CW'(nv_q) + SKEW - CW'(1);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? head : '0;
    assign out_last  = out_valid && (pop_cnt == nv_q - CNT_W'(1));
    assign busy      = state != IDLE;
    assign done      = zero_done || (state == DRAIN && empty);
    assign overflow  = ovf;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        push    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok && num_vec != '0) begin
                    state_n = WAIT;
                    cnt_n   = CW'(ARRAY_LAT - 2);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = CAPTURE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            CAPTURE: begin
                push = cnt >= SKEW;
                if (cnt == cap_end) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (empty) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nv_q      <= '0;
            pop_cnt   <= '0;
            zero_done <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            zero_done <= start_ok && (num_vec == '0);
            if (start_ok) begin
                nv_q    <= num_vec;
                pop_cnt <= '0;
                ovf     <= 1'b0;
            end else begin
                if (pop) pop_cnt <= pop_cnt + CNT_W'(1);
                if (push && full && !pop) ovf <= 1'b1;
            end
        end
    end

    psum_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .data      (head)
    );

endmodule

// File: tb/tb_psum_drain_fp16.sv
// Directed bench for psum_drain_fp16 with hand-computed expectations.
module tb_psum_drain_fp16;

    localparam int COLS  = 4;
    localparam int LAT   = 36;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic [63:0]      psum_col = '0;
    logic             out_ready = 1'b0;
    logic [63:0]      out_data;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             overflow;

    always #5 clk = ~clk;

    psum_drain_fp16 #(
        .COLS       (COLS),
        .ARRAY_LAT  (LAT),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_vec   (num_vec),
        .psum_col  (psum_col),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    int n_chk = 0;
    int n_pass = 0;
    int rel = 0;
    int job_n = 0;
    int busy_drops = 0;
    logic busy_watch = 1'b0;
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic [63:0] q_data [$];
    logic q_last [$];
    int q_rel [$];
    int done_rel [$];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [63:0] vec_word(input int k);
        logic [63:0] w;
        for (int c = 0; c < COLS; c++)
            w[c*16 +: 16] = 16'h3C00 + 16'(16 * k + c);
        return w;
    endfunction

    task automatic drive_psum();
        for (int c = 0; c < COLS; c++) begin
            int k;
            k = rel - LAT - c;
            if (k >= 0 && k < job_n)
                psum_col[c*16 +: 16] = 16'h3C00 + 16'(16 * k + c);
            else
                psum_col[c*16 +: 16] = 16'h7E00 ^ 16'(rel * 7 + c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        drive_psum();
    endtask

    task automatic start_job(input int n);
        q_data.delete();
        q_last.delete();
        q_rel.delete();
        done_rel.delete();
        job_n = n;
        num_vec = CNT_W'(n);
        start = 1'b1;
        rel = 0;
        drive_psum();
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_data"}, out_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    task automatic chk_words(input string tag, input int n,
                             input int first, input logic has_last);
        chk({tag, "_nwords"}, 64'(q_data.size()), 64'(n));
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), q_data[i], vec_word(i));
            chk($sformatf("%s_last%0d", tag, i), 64'(q_last[i]),
                64'(has_last && i == n - 1));
            chk($sformatf("%s_rel%0d", tag, i), 64'(q_rel[i]),
                64'(first + i));
        end
    endtask

    task automatic chk_done(input string tag, input int at);
        chk({tag, "_ndone"}, 64'(done_rel.size()), 64'd1);
        if (done_rel.size() > 0)
            chk({tag, "_done_at"}, 64'(done_rel[0]), 64'(at));
    endtask

    task automatic basic_job(input string tag);
        out_ready = 1'b1;
        start_job(3);
        chk({tag, "_ovf_clr"}, 64'(overflow), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        while (rel < 60) tick();
        chk_words(tag, 3, 40, 1'b1);
        chk_done(tag, 43);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_rel.push_back(rel);
            end
            if (done) done_rel.push_back(rel);
            if (busy_watch && !busy) busy_drops++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("reset");
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        basic_job("basic");

        out_ready = 1'b0;
        start_job(8);
        while (rel < 60) tick();
        chk("bp_ovf", 64'(overflow), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_none_yet", 64'(q_data.size()), 64'd0);
        out_ready = 1'b1;
        while (rel < 80) tick();
        chk_words("bp", 8, 60, 1'b1);
        chk_done("bp", 68);
        chk("bp_ovf_end", 64'(overflow), 64'd0);

        out_ready = 1'b0;
        start_job(10);
        while (rel < 47) tick();
        chk("ovf_before", 64'(overflow), 64'd0);
        tick();
        chk("ovf_set", 64'(overflow), 64'd1);
        while (rel < 80) tick();
        out_ready = 1'b1;
        while (rel < 100) tick();
        chk_words("ovf", 8, 80, 1'b0);
        chk_done("ovf", 88);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_idle", 64'(busy), 64'd0);

        out_ready = 1'b1;
        start_job(3);
        busy_watch = 1'b1;
        while (rel < 5) tick();
        start = 1'b1;
        num_vec = CNT_W'(2);
        tick();
        start = 1'b0;
        while (rel < 44) tick();
        busy_watch = 1'b0;
        while (rel < 60) tick();
        chk_words("sbusy", 3, 40, 1'b1);
        chk_done("sbusy", 43);
        chk("sbusy_drops", 64'(busy_drops), 64'd0);

        start_job(0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        tick();
        chk("zero_done_off", 64'(done), 64'd0);
        chk("zero_busy2", 64'(busy), 64'd0);
        repeat (10) tick();
        chk("zero_words", 64'(q_data.size()), 64'd0);
        chk_done("zero", 1);

        out_ready = 1'b1;
        start_job(3);
        while (rel < 38) tick();
        rst = 1'b0;
        #1;
        chk_reset_outs("midrst");
        repeat (3) tick();
        rst = 1'b1;
        repeat (60) tick();
        chk("midrst_words", 64'(q_data.size()), 64'd0);
        chk("midrst_ndone", 64'(done_rel.size()), 64'd0);
        basic_job("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
